// File: rtl/led_pattern_drv_if.sv
// led_pattern_drv_if: request/status bundle between a blink requester and the LED pattern driver
interface led_pattern_drv_if;
   logic       req;
   logic [3:0] req_cnt;
   logic       abort;
   logic       led;
   logic       busy;
   logic       done;
   logic [3:0] blink_left;
   modport master (output req, req_cnt, abort, input led, busy, done, blink_left);
   modport slave  (input req, req_cnt, abort, output led, busy, done, blink_left);
endinterface

// File: rtl/led_pattern_drv.sv
// led_pattern_drv: turns a single-cycle blink request into N timed on/off blinks on a registered LED pin
module led_pattern_drv #(
   parameter int C_CLK_FREQ       = 100_000,
   parameter int C_ON_TIME        = 200,
   parameter int C_OFF_TIME       = 200,
   parameter int C_LED_ACTIVE_LOW = 1
) (
   input logic              clk,
   input logic              reset,
   led_pattern_drv_if.slave bus
);
   localparam logic [31:0] ON_CYC  = 32'(C_CLK_FREQ * C_ON_TIME);
   localparam logic [31:0] OFF_CYC = 32'(C_CLK_FREQ * C_OFF_TIME);
   localparam logic        DARK    = (C_LED_ACTIVE_LOW != 0);
   localparam logic        LIT     = !DARK;
   if (C_CLK_FREQ * C_ON_TIME < 1 || C_CLK_FREQ * C_OFF_TIME < 1) begin : g_cfg_err
      $error("led_pattern_drv: on and off phases must each last at least one cycle");
   end
   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
   state_t      state;
   logic [31:0] cnt;
   // Pattern FSM: counter restarts on every phase change; the trailing dark phase is always emitted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         bus.led        <= DARK;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.blink_left <= '0;
      end else if (bus.abort) begin
         state          <= IDLE;
         cnt            <= '0;
         bus.led        <= DARK;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.blink_left <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.req && bus.req_cnt != 4'd0) begin
               state          <= ON;
               cnt            <= '0;
               bus.led        <= LIT;
               bus.busy       <= 1'b1;
               bus.blink_left <= bus.req_cnt;
            end
            ON: if (cnt == ON_CYC - 32'd1) begin
               state   <= OFF;
               cnt     <= '0;
               bus.led <= DARK;
            end else cnt <= cnt + 32'd1;
            OFF: if (cnt == OFF_CYC - 32'd1) begin
               cnt <= '0;
               if (bus.blink_left > 4'd1) begin
                  state          <= ON;
                  bus.led        <= LIT;
                  bus.blink_left <= bus.blink_left - 4'd1;
               end else begin
                  state          <= IDLE;
                  bus.busy       <= 1'b0;
                  bus.done       <= 1'b1;
                  bus.blink_left <= '0;
               end
            end else cnt <= cnt + 32'd1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_led_pattern_drv.sv
// tb_led_pattern_drv: directed checks of blink timing, ignored requests, abort and async reset
module tb_led_pattern_drv;
   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   led_pattern_drv_if ia ();
   led_pattern_drv_if ib ();
   led_pattern_drv #(.C_CLK_FREQ(1), .C_ON_TIME(4), .C_OFF_TIME(3), .C_LED_ACTIVE_LOW(1))
      dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
   led_pattern_drv #(.C_CLK_FREQ(1), .C_ON_TIME(4), .C_OFF_TIME(3), .C_LED_ACTIVE_LOW(0))
      dut_b (.clk(clk), .reset(reset), .bus(ib.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input int cyc, input logic l, input logic b, input logic d,
                      input logic [3:0] bl, input logic el, input logic eb, input logic ed,
                      input logic [3:0] ebl);
      checks++;
      assert (l === el) else begin
         failures++;
         $error("FAIL %s[%0d] led got=%b want=%b", tag, cyc, l, el);
      end
      checks++;
      assert (b === eb) else begin
         failures++;
         $error("FAIL %s[%0d] busy got=%b want=%b", tag, cyc, b, eb);
      end
      checks++;
      assert (d === ed) else begin
         failures++;
         $error("FAIL %s[%0d] done got=%b want=%b", tag, cyc, d, ed);
      end
      checks++;
      assert (bl === ebl) else begin
         failures++;
         $error("FAIL %s[%0d] blink_left got=%0d want=%0d", tag, cyc, bl, ebl);
      end
   endtask
   initial begin
      reset = 1'b1;
      ia.req = 1'b0; ia.req_cnt = 4'd0; ia.abort = 1'b0;
      ib.req = 1'b0; ib.req_cnt = 4'd0; ib.abort = 1'b0;
      step();
      step();
      chk("rst_a", 0, ia.led, ia.busy, ia.done, ia.blink_left, 1'b1, 1'b0, 1'b0, 4'd0);
      chk("rst_b", 0, ib.led, ib.busy, ib.done, ib.blink_left, 1'b0, 1'b0, 1'b0, 4'd0);
      reset = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         chk("idle", i, ia.led, ia.busy, ia.done, ia.blink_left, 1'b1, 1'b0, 1'b0, 4'd0);
      end
      ia.req = 1'b1; ia.req_cnt = 4'd2;
      step();
      ia.req = 1'b0; ia.req_cnt = 4'd0;
      for (int i = 1; i <= 16; i++) begin
         chk("two", i, ia.led, ia.busy, ia.done, ia.blink_left,
             !((i >= 1 && i <= 4) || (i >= 8 && i <= 11)), i <= 14, i == 15,
             i <= 7 ? 4'd2 : (i <= 14 ? 4'd1 : 4'd0));
         step();
      end
      ia.req = 1'b1; ia.req_cnt = 4'd0;
      step();
      ia.req = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         chk("zero", i, ia.led, ia.busy, ia.done, ia.blink_left, 1'b1, 1'b0, 1'b0, 4'd0);
         step();
      end
      ia.req = 1'b1; ia.req_cnt = 4'd3;
      step();
      ia.req = 1'b0; ia.req_cnt = 4'd0;
      for (int i = 1; i <= 23; i++) begin
         chk("busyreq", i, ia.led, ia.busy, ia.done, ia.blink_left,
             i > 21 || ((i - 1) % 7) >= 4, i <= 21, i == 22,
             i <= 7 ? 4'd3 : (i <= 14 ? 4'd2 : (i <= 21 ? 4'd1 : 4'd0)));
         if (i == 6) begin
            ia.req = 1'b1; ia.req_cnt = 4'd5;
         end
         step();
         ia.req = 1'b0; ia.req_cnt = 4'd0;
      end
      ia.req = 1'b1; ia.req_cnt = 4'd4;
      step();
      ia.req = 1'b0; ia.req_cnt = 4'd0;
      for (int i = 1; i <= 9; i++) begin
         chk("abort_run", i, ia.led, ia.busy, ia.done, ia.blink_left,
             ((i - 1) % 7) >= 4, 1'b1, 1'b0, i <= 7 ? 4'd4 : 4'd3);
         if (i == 9) begin
            ia.abort = 1'b1; ia.req = 1'b1; ia.req_cnt = 4'd2;
         end
         step();
      end
      ia.abort = 1'b0; ia.req = 1'b0; ia.req_cnt = 4'd0;
      for (int i = 10; i <= 16; i++) begin
         chk("abort_idle", i, ia.led, ia.busy, ia.done, ia.blink_left, 1'b1, 1'b0, 1'b0, 4'd0);
         step();
      end
      ia.req = 1'b1; ia.req_cnt = 4'd1;
      step();
      ia.req = 1'b0; ia.req_cnt = 4'd0;
      chk("after_abort", 1, ia.led, ia.busy, ia.done, ia.blink_left, 1'b0, 1'b1, 1'b0, 4'd1);
      step();
      chk("after_abort", 2, ia.led, ia.busy, ia.done, ia.blink_left, 1'b0, 1'b1, 1'b0, 4'd1);
      reset = 1'b1;
      #1;
      chk("async_rst", 0, ia.led, ia.busy, ia.done, ia.blink_left, 1'b1, 1'b0, 1'b0, 4'd0);
      #1;
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         step();
         chk("post_rst", i, ia.led, ia.busy, ia.done, ia.blink_left, 1'b1, 1'b0, 1'b0, 4'd0);
      end
      ib.req = 1'b1; ib.req_cnt = 4'd1;
      step();
      ib.req = 1'b0; ib.req_cnt = 4'd0;
      for (int i = 1; i <= 9; i++) begin
         chk("act_high", i, ib.led, ib.busy, ib.done, ib.blink_left,
             i <= 4, i <= 7, i == 8, i <= 7 ? 4'd1 : 4'd0);
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
